// File: rtl/fsrc_pkg.sv
// Shared state encoding and constants for the FSRC RX control path.
package fsrc_pkg;

  localparam int TRIG_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_SYSREF = 2'd1,
    ST_APPLY_DLY   = 2'd2,
    ST_ACCUM_DLY   = 2'd3
  } fsrc_state_e;

endpackage

// File: rtl/fsrc_edge_detect.sv
// Rising-edge detector: compares the input with its value one clock earlier.
module fsrc_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/rx_fsrc_ctrl.sv
// RX frequency-source control sequencer: trigger capture, optional SYSREF alignment,
// delayed control-word apply and accumulator reset. SYSREF alignment: FSRC_RX_SYSREF_ALIGN_EN.
module rx_fsrc_ctrl
  import fsrc_pkg::*;
#(
  parameter int CTRL_WIDTH    = 40,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        sysref,
  input  logic                        trig_in,
  input  logic [CTRL_WIDTH-1:0]       ctrl_in,
  input  logic [COUNTER_WIDTH-1:0]    apply_delay_cnt,
  input  logic [COUNTER_WIDTH-1:0]    accum_reset_cnt,
  input  logic                        rx_data_start,
  input  logic                        clear_overrun,
  output logic [CTRL_WIDTH-1:0]       ctrl_out,
  output logic                        ctrl_update,
  output logic                        accum_reset,
  output logic                        rx_data_en,
  output logic                        busy,
  output logic                        overrun,
  output logic [TRIG_COUNT_WIDTH-1:0] trig_count
);

  fsrc_state_e                 state_q, state_d;
  logic [CTRL_WIDTH-1:0]       hold_q, hold_d;
  logic [CTRL_WIDTH-1:0]       ctrl_out_q, ctrl_out_d;
  logic [COUNTER_WIDTH-1:0]    cnt_q, cnt_d;
  logic                        ctrl_update_q, ctrl_update_d;
  logic                        accum_reset_q, accum_reset_d;
  logic                        rx_data_en_q, rx_data_en_d;
  logic                        overrun_q, overrun_d;
  logic                        busy_q;
  logic [TRIG_COUNT_WIDTH-1:0] trig_count_q, trig_count_d;
  logic                        trig_rise;
  logic                        rx_start_rise;

  fsrc_edge_detect u_trig_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (trig_in),
    .rise_o (trig_rise)
  );

  fsrc_edge_detect u_rx_start_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (rx_data_start),
    .rise_o (rx_start_rise)
  );

`ifdef FSRC_RX_SYSREF_ALIGN_EN
  logic sysref_rise;

  fsrc_edge_detect u_sysref_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (sysref),
    .rise_o (sysref_rise)
  );
`else
  logic unused_sysref;
  assign unused_sysref = sysref;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping enable aborts any sequence in progress without further pulses.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig_rise) begin
`ifdef FSRC_RX_SYSREF_ALIGN_EN
            state_d = ST_WAIT_SYSREF;
`else
            state_d = ST_APPLY_DLY;
`endif
          end
        end
`ifdef FSRC_RX_SYSREF_ALIGN_EN
        ST_WAIT_SYSREF: begin
          if (sysref_rise) begin
            state_d = ST_APPLY_DLY;
          end
        end
`endif
        ST_APPLY_DLY: begin
          if (cnt_q == '0) begin
            state_d = ST_ACCUM_DLY;
          end
        end
        ST_ACCUM_DLY: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hold_d        = hold_q;
    ctrl_out_d    = ctrl_out_q;
    cnt_d         = cnt_q;
    ctrl_update_d = 1'b0;
    accum_reset_d = 1'b0;
    trig_count_d  = trig_count_q;
    overrun_d     = overrun_q;
    rx_data_en_d  = rx_data_en_q;

    // A rejected trigger must win over a simultaneous clear.
    if (trig_rise && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end

    if (!enable) begin
      rx_data_en_d = 1'b0;
    end else if (rx_start_rise) begin
      rx_data_en_d = 1'b1;
    end

    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (trig_rise) begin
            hold_d       = ctrl_in;
            cnt_d        = apply_delay_cnt;
            trig_count_d = trig_count_q + TRIG_COUNT_WIDTH'(1);
          end
        end
        ST_APPLY_DLY: begin
          if (cnt_q == '0) begin
            ctrl_out_d    = hold_q;
            ctrl_update_d = 1'b1;
            cnt_d         = accum_reset_cnt;
          end else begin
            cnt_d = cnt_q - COUNTER_WIDTH'(1);
          end
        end
        ST_ACCUM_DLY: begin
          if (cnt_q == '0) begin
            accum_reset_d = 1'b1;
          end else begin
            cnt_d = cnt_q - COUNTER_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q        <= '0;
      ctrl_out_q    <= '0;
      cnt_q         <= '0;
      ctrl_update_q <= 1'b0;
      accum_reset_q <= 1'b0;
      trig_count_q  <= '0;
      overrun_q     <= 1'b0;
      rx_data_en_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      ctrl_out_q    <= ctrl_out_d;
      cnt_q         <= cnt_d;
      ctrl_update_q <= ctrl_update_d;
      accum_reset_q <= accum_reset_d;
      trig_count_q  <= trig_count_d;
      overrun_q     <= overrun_d;
      rx_data_en_q  <= rx_data_en_d;
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign ctrl_out    = ctrl_out_q;
  assign ctrl_update = ctrl_update_q;
  assign accum_reset = accum_reset_q;
  assign rx_data_en  = rx_data_en_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign trig_count  = trig_count_q;

endmodule

// File: tb/tb_rx_fsrc_ctrl.sv
// Bench for rx_fsrc_ctrl: directed scenarios plus random stimulus against a
// timestamp-based reference model of the trigger/apply/accumulate sequence.
module tb_rx_fsrc_ctrl;

  localparam int CW = 40;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset, enable, sysref, trig_in, rx_data_start, clear_overrun;
  logic [CW-1:0] ctrl_in;
  logic [NW-1:0] apply_delay_cnt, accum_reset_cnt;
  logic [CW-1:0] ctrl_out;
  logic          ctrl_update, accum_reset, rx_data_en, busy, overrun;
  logic [15:0]   trig_count;

  rx_fsrc_ctrl #(.CTRL_WIDTH(CW), .COUNTER_WIDTH(NW)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sysref          (sysref),
    .trig_in         (trig_in),
    .ctrl_in         (ctrl_in),
    .apply_delay_cnt (apply_delay_cnt),
    .accum_reset_cnt (accum_reset_cnt),
    .rx_data_start   (rx_data_start),
    .clear_overrun   (clear_overrun),
    .ctrl_out        (ctrl_out),
    .ctrl_update     (ctrl_update),
    .accum_reset     (accum_reset),
    .rx_data_en      (rx_data_en),
    .busy            (busy),
    .overrun         (overrun),
    .trig_count      (trig_count)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  bit     chk_on = 1'b1;
  longint cyc = 0;

  // Reference model: a job is either waiting for SYSREF or has absolute
  // cycle numbers at which its update and accumulator-reset pulses appear.
  bit            m_job = 1'b0, m_wait = 1'b0;
  longint        m_upd_at = 0, m_acc_at = 0;
  logic [CW-1:0] m_held = '0;
  longint        m_apply = 0;
  bit            p_trig = 1'b0, p_sref = 1'b0, p_rx = 1'b0;
  logic [CW-1:0] e_ctrl_out = '0;
  bit            e_upd = 1'b0, e_acc = 1'b0, e_rx = 1'b0, e_busy = 1'b0, e_ovr = 1'b0;
  logic [15:0]   e_tc = '0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit te, se, re;
    te = trig_in && !p_trig;
    se = sysref && !p_sref;
    re = rx_data_start && !p_rx;
    e_upd = 1'b0;
    e_acc = 1'b0;
    if (reset) begin
      m_job = 1'b0; m_wait = 1'b0; m_held = '0;
      e_ctrl_out = '0; e_rx = 1'b0; e_ovr = 1'b0; e_tc = '0;
      p_trig = 1'b0; p_sref = 1'b0; p_rx = 1'b0;
    end else begin
      p_trig = trig_in; p_sref = sysref; p_rx = rx_data_start;
      if (te && m_job) e_ovr = 1'b1;
      else if (clear_overrun) e_ovr = 1'b0;
      if (!enable) begin
        m_job = 1'b0;
        e_rx  = 1'b0;
      end else begin
        if (re) e_rx = 1'b1;
        if (m_job) begin
          if (m_wait) begin
            if (se) begin
              m_wait   = 1'b0;
              m_upd_at = cyc + 2 + m_apply;
            end
          end else if (cyc + 1 == m_upd_at) begin
            e_upd      = 1'b1;
            e_ctrl_out = m_held;
            m_acc_at   = cyc + 2 + longint'(accum_reset_cnt);
          end else if (cyc + 1 == m_acc_at) begin
            e_acc = 1'b1;
            m_job = 1'b0;
          end
        end else if (te) begin
          m_job    = 1'b1;
          m_held   = ctrl_in;
          m_apply  = longint'(apply_delay_cnt);
          m_acc_at = 0;
          e_tc     = e_tc + 16'd1;
`ifdef FSRC_RX_SYSREF_ALIGN_EN
          m_wait   = 1'b1;
          m_upd_at = 0;
`else
          m_wait   = 1'b0;
          m_upd_at = cyc + 2 + m_apply;
`endif
        end
      end
    end
    e_busy = m_job;
    cyc++;
  endtask

  task automatic compare_all();
    chk_eq("ctrl_out",    64'(ctrl_out),    64'(e_ctrl_out));
    chk_eq("ctrl_update", 64'(ctrl_update), 64'(e_upd));
    chk_eq("accum_reset", 64'(accum_reset), 64'(e_acc));
    chk_eq("rx_data_en",  64'(rx_data_en),  64'(e_rx));
    chk_eq("busy",        64'(busy),        64'(e_busy));
    chk_eq("overrun",     64'(overrun),     64'(e_ovr));
    chk_eq("trig_count",  64'(trig_count),  64'(e_tc));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (chk_on) compare_all();
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [63:0] r64;

    reset = 1'b1; enable = 1'b1; sysref = 1'b0; trig_in = 1'b0;
    rx_data_start = 1'b0; clear_overrun = 1'b0; ctrl_in = '0;
    apply_delay_cnt = '0; accum_reset_cnt = '0;
    tick(); tick();
    chk_eq("reset_trig_count", 64'(trig_count), 64'd0);
    reset = 1'b0;
    tick();
    $display("reset: ctrl_out=%h busy=%0d trig_count=%0d", ctrl_out, busy, trig_count);

    // Trigger apply with apply delay 3, then accumulator reset with delay 2.
    ctrl_in = 40'hA5_0000_0001; apply_delay_cnt = 4'd3; accum_reset_cnt = 4'd2; trig_in = 1'b1;
`ifdef FSRC_RX_SYSREF_ALIGN_EN
    for (int i = 0; i < 10; i++) begin
      tick();
      ctrl_in = 40'h5A_FFFF_FFFE;
    end
    sysref = 1'b1;
`endif
    k = 0;
    do begin
      tick();
      k++;
      sysref  = 1'b0;
      ctrl_in = 40'h5A_FFFF_FFFE;
    end while (!ctrl_update && k < 12);
    chk_eq("apply_latency", 64'(k), 64'd5);
    chk_eq("apply_word", 64'(ctrl_out), 64'h00A5_0000_0001);
    chk_eq("apply_trig_count", 64'(trig_count), 64'd1);
    k = 0;
    do begin
      tick();
      k++;
    end while (!accum_reset && k < 10);
    chk_eq("accum_latency", 64'(k), 64'd3);
    chk_eq("accum_busy", 64'(busy), 64'd0);
    $display("apply: ctrl_out=%h trig_count=%0d accum_lat=%0d", ctrl_out, trig_count, k);

    // Overrun: rejected triggers while busy; set beats a same-cycle clear.
    trig_in = 1'b0; tick();
    ctrl_in = 40'h11_2233_4455; apply_delay_cnt = 4'd6; accum_reset_cnt = 4'd1; trig_in = 1'b1;
    tick();
    trig_in = 1'b0; sysref = 1'b1; tick();
    sysref = 1'b0; trig_in = 1'b1; tick();
    chk_eq("ovr_set", 64'(overrun), 64'd1);
    chk_eq("ovr_trig_count", 64'(trig_count), 64'd2);
    chk_eq("ovr_ctrl_out", 64'(ctrl_out), 64'h00A5_0000_0001);
    trig_in = 1'b0; tick();
    trig_in = 1'b1; clear_overrun = 1'b1; tick();
    chk_eq("ovr_set_wins", 64'(overrun), 64'd1);
    tick();
    clear_overrun = 1'b0;
    chk_eq("ovr_cleared", 64'(overrun), 64'd0);
    k = 0;
    while (busy && k < 30) begin
      tick();
      k++;
    end
    chk_eq("ovr_idle", 64'(busy), 64'd0);
    chk_eq("ovr_applied", 64'(ctrl_out), 64'h0011_2233_4455);
    $display("overrun: ctrl_out=%h trig_count=%0d", ctrl_out, trig_count);

    // Abort by enable drop, then rx_data_en set/clear.
    trig_in = 1'b0; tick();
    ctrl_in = 40'h77_0000_0077; apply_delay_cnt = 4'd0; accum_reset_cnt = 4'd0; trig_in = 1'b1;
    tick();
    enable = 1'b0; tick();
    chk_eq("abort_busy", 64'(busy), 64'd0);
    chk_eq("abort_upd", 64'(ctrl_update), 64'd0);
    enable = 1'b1; tick();
    chk_eq("abort_no_upd", 64'(ctrl_update), 64'd0);
    chk_eq("abort_ctrl_held", 64'(ctrl_out), 64'h0011_2233_4455);
    rx_data_start = 1'b1; tick();
    chk_eq("rx_en_set", 64'(rx_data_en), 64'd1);
    rx_data_start = 1'b0; enable = 1'b0; tick();
    chk_eq("rx_en_clear", 64'(rx_data_en), 64'd0);
    enable = 1'b1; tick();
    $display("abort: busy=%0d rx_data_en=%0d", busy, rx_data_en);

    // Trigger counter wrap: accept, abort, repeat.
    chk_on = 1'b0;
    trig_in = 1'b0; tick();
    for (int g = 0; g < 70000 && e_tc != 16'hFFFF; g++) begin
      trig_in = 1'b1; enable = 1'b1; tick();
      trig_in = 1'b0; enable = 1'b0; tick();
    end
    enable = 1'b1; chk_on = 1'b1;
    tick();
    chk_eq("wrap_preload", 64'(trig_count), 64'hFFFF);
    trig_in = 1'b1; tick();
    chk_eq("wrap_zero", 64'(trig_count), 64'h0000);
    $display("wrap: trig_count=%h", trig_count);

    // Reset in the middle of the accumulator delay dominates all inputs.
    trig_in = 1'b0; enable = 1'b0; tick();
    enable = 1'b1; apply_delay_cnt = 4'd0; accum_reset_cnt = 4'd6; tick();
    trig_in = 1'b1; tick();
    trig_in = 1'b0; sysref = 1'b1; rx_data_start = 1'b1; tick();
    sysref = 1'b0; trig_in = 1'b1; tick();
    trig_in = 1'b0; tick();
    chk_eq("pre_rst_busy", 64'(busy), 64'd1);
    chk_eq("pre_rst_ovr", 64'(overrun), 64'd1);
    chk_eq("pre_rst_rx_en", 64'(rx_data_en), 64'd1);
    reset = 1'b1; trig_in = 1'b1; rx_data_start = 1'b0; clear_overrun = 1'b0; tick();
    chk_eq("rst_ctrl_out", 64'(ctrl_out), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_ovr", 64'(overrun), 64'd0);
    chk_eq("rst_rx_en", 64'(rx_data_en), 64'd0);
    chk_eq("rst_trig_count", 64'(trig_count), 64'd0);
    chk_eq("rst_pulses", 64'({ctrl_update, accum_reset}), 64'd0);
    reset = 1'b0; trig_in = 1'b0; tick();
    $display("reset_mid_accum: busy=%0d trig_count=%0d", busy, trig_count);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 399) == 0);
      enable          = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 3) == 0) trig_in = ~trig_in;
      sysref          = ($urandom_range(0, 5) == 0);
      rx_data_start   = ($urandom_range(0, 7) == 0);
      clear_overrun   = ($urandom_range(0, 15) == 0);
      r64             = {$urandom(), $urandom()};
      ctrl_in         = r64[CW-1:0];
      apply_delay_cnt = NW'($urandom_range(0, 5));
      accum_reset_cnt = NW'($urandom_range(0, 5));
      tick();
    end
    $display("random: trig_count=%0d overrun=%0d", trig_count, overrun);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
